// File: rtl/decoder_3to8_sync.sv
// Registered 3-to-8 decoder with enable and polarity select; 1-cycle latency.
// No backpressure: a new code is accepted every cycle that in_valid is high.
module decoder_3to8_sync #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] A,
  input  logic       en,
  input  logic       in_valid,
  output logic [7:0] D,
  output logic       out_valid
);

  localparam logic [7:0] IDLE_LINES = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] onehot;
  logic [7:0] d_d, d_q;
  logic       vld_d, vld_q;

  always_comb begin
    onehot = 8'h00;
    if (en) onehot[A] = 1'b1;
  end

  // Polarity inversion happens before the flop so D comes straight from a register.
  always_comb begin
    d_d   = d_q;
    vld_d = in_valid;
    if (in_valid) d_d = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= IDLE_LINES;
      vld_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      vld_q <= vld_d;
    end
  end

  assign D         = d_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_decoder_3to8_sync.sv
// Bench for decoder_3to8_sync: both polarities side by side, vector table,
// reset corner cases and a randomized run against an arithmetic model.
module tb_decoder_3to8_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] A;
  logic       en;
  logic       in_valid;
  logic [7:0] d_hi, d_lo;
  logic       v_hi, v_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_3to8_sync #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .A(A), .en(en), .in_valid(in_valid),
    .D(d_hi), .out_valid(v_hi)
  );

  decoder_3to8_sync #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .A(A), .en(en), .in_valid(in_valid),
    .D(d_lo), .out_valid(v_lo)
  );

  typedef struct {
    logic [2:0] a;
    logic       en;
    logic       iv;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
    logic       exp_v;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] e_hi, input logic [7:0] e_lo,
                           input logic e_v);
    check({name, " D(AL=0)"}, d_hi, e_hi);
    check({name, " D(AL=1)"}, d_lo, e_lo);
    check({name, " out_valid(AL=0)"}, {7'd0, v_hi}, {7'd0, e_v});
    check({name, " out_valid(AL=1)"}, {7'd0, v_lo}, {7'd0, e_v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: last accepted decode for each polarity.
  logic [7:0] m_hi, m_lo;
  logic       m_v;
  int         m_en;

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 1'b1, 8'h01, 8'hFE, 1'b1};
    vecs[1]  = '{3'd1, 1'b1, 1'b1, 8'h02, 8'hFD, 1'b1};
    vecs[2]  = '{3'd2, 1'b1, 1'b1, 8'h04, 8'hFB, 1'b1};
    vecs[3]  = '{3'd3, 1'b1, 1'b1, 8'h08, 8'hF7, 1'b1};
    vecs[4]  = '{3'd4, 1'b1, 1'b1, 8'h10, 8'hEF, 1'b1};
    vecs[5]  = '{3'd5, 1'b1, 1'b1, 8'h20, 8'hDF, 1'b1};
    vecs[6]  = '{3'd6, 1'b1, 1'b1, 8'h40, 8'hBF, 1'b1};
    vecs[7]  = '{3'd7, 1'b1, 1'b1, 8'h80, 8'h7F, 1'b1};
    vecs[8]  = '{3'd5, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1};
    vecs[9]  = '{3'd3, 1'b1, 1'b1, 8'h08, 8'hF7, 1'b1};
    vecs[10] = '{3'd6, 1'b1, 1'b0, 8'h08, 8'hF7, 1'b0};
    vecs[11] = '{3'd6, 1'b0, 1'b0, 8'h08, 8'hF7, 1'b0};
    vecs[12] = '{3'd2, 1'b1, 1'b1, 8'h04, 8'hFB, 1'b1};

    rst_n = 1'b0; A = 3'd0; en = 1'b0; in_valid = 1'b0;
    #12;
    check_all("reset", 8'h00, 8'hFF, 1'b0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      A = vecs[i].a; en = vecs[i].en; in_valid = vecs[i].iv;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_v);
    end

    // Asynchronous reset between edges while D = 00100000.
    A = 3'd5; en = 1'b1; in_valid = 1'b1;
    step();
    check_all("load5", 8'h20, 8'hDF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'hFF, 1'b0);

    // Requests during reset are ignored.
    A = 3'd7; in_valid = 1'b1;
    step();
    check_all("rst_hold", 8'h00, 8'hFF, 1'b0);
    rst_n = 1'b1;
    step();
    check_all("post_rst", 8'h80, 8'h7F, 1'b1);

    // Reset asserted ahead of an edge carrying a request: reset wins.
    A = 3'd1; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    step();
    check_all("rst_dominates", 8'h00, 8'hFF, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    check_all("idle_after_rst", 8'h00, 8'hFF, 1'b0);

    m_hi = 8'h00; m_lo = 8'hFF; m_v = 1'b0; m_en = 0;
    for (int c = 0; c < 1200; c++) begin
      A = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      m_v = in_valid;
      if (in_valid) begin
        m_en = en;
        m_hi = en ? 8'(2 ** int'(A)) : 8'h00;
        m_lo = 8'(255 - int'(m_hi));
      end
      step();
      check_all("rand", m_hi, m_lo, m_v);
      if (v_hi) check("rand popcount", 8'($countones(d_hi)), 8'(m_en));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
